// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared types and helpers for the three-way round-robin arbiter.
// Holds state encodings, the idle select code and pointer helpers.
package mux3_rr_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   localparam logic [1:0] SEL_IDLE = 2'b11;

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   function automatic logic [2:0] onehot3(input logic [1:0] s);
      logic [2:0] m;
      m = 3'b000;
      case (s)
         2'd0:    m = 3'b001;
         2'd1:    m = 3'b010;
         2'd2:    m = 3'b100;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   // First requester at or after ptr, wrapping mod 3; SEL_IDLE if none.
   function automatic logic [1:0] rr_pick(
      input logic [2:0] req,
      input logic [1:0] ptr
   );
      logic [1:0] o1;
      logic [1:0] o2;
      o1 = inc3(ptr);
      o2 = inc3(o1);
      if (|(req & onehot3(ptr)))
         return ptr;
      else if (|(req & onehot3(o1)))
         return o1;
      else if (|(req & onehot3(o2)))
         return o2;
      else
         return SEL_IDLE;
   endfunction

endpackage

// File: rtl/mux3_rr_arbiter_mux.sv
// Three-input data multiplexer for the arbiter's shared path.
// The idle select code drives an all-zero output.
module Multiplexer3to1 #(
   parameter int NBits = 32
) (
   input  logic [1:0]       sel,
   input  logic [NBits-1:0] d0,
   input  logic [NBits-1:0] d1,
   input  logic [NBits-1:0] d2,
   output logic [NBits-1:0] y
);

   always_comb begin
      y = '0;
      case (sel)
         2'b00:   y = d0;
         2'b01:   y = d1;
         2'b10:   y = d2;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Three-requester round-robin arbiter with bounded hold and muxed data.
// Grant, Selector and Out_Valid are registered from one next-owner decision.
module mux3_rr_arbiter
   import mux3_rr_arbiter_pkg::*;
#(
   parameter int NBits   = 32,
   parameter int MaxHold = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       Request,
   input  logic [NBits-1:0] Data0,
   input  logic [NBits-1:0] Data1,
   input  logic [NBits-1:0] Data2,
   output logic [2:0]       Grant,
   output logic [1:0]       Selector,
   output logic [NBits-1:0] Out_Data,
   output logic             Out_Valid
);

   localparam logic [3:0] HOLD_LIM = 4'(MaxHold - 1);

   arb_state_e state_q;
   arb_state_e state_d;
   logic [1:0] sel_q;
   logic [1:0] sel_d;
   logic [1:0] next_q;
   logic [1:0] next_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic [2:0] grant_q;
   logic       valid_q;

   logic [2:0] own_mask;
   logic       own_req;
   logic       others;
   logic [1:0] pick;
   logic [1:0] rel_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sel_q   <= SEL_IDLE;
         next_q  <= 2'd0;
         cnt_q   <= 4'd0;
         grant_q <= 3'b000;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         next_q  <= next_d;
         cnt_q   <= cnt_d;
         grant_q <= onehot3(sel_d);
         valid_q <= (sel_d != SEL_IDLE);
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      next_d   = next_q;
      cnt_d    = cnt_q;
      own_mask = onehot3(sel_q);
      own_req  = |(Request & own_mask);
      others   = |(Request & ~own_mask);
      rel_ptr  = inc3(sel_q);
      pick     = SEL_IDLE;
      unique case (state_q)
         IDLE: begin
            pick = rr_pick(Request, next_q);
            if (pick != SEL_IDLE) begin
               state_d = OWN;
               sel_d   = pick;
               cnt_d   = 4'd0;
            end
         end
         OWN: begin
            if (own_req && ((cnt_q < HOLD_LIM) || !others)) begin
               if (cnt_q < HOLD_LIM)
                  cnt_d = cnt_q + 4'd1;
            end else begin
               // Releasing owner drops to lowest priority for this pick.
               next_d = rel_ptr;
               pick   = rr_pick(Request, rel_ptr);
               cnt_d  = 4'd0;
               sel_d  = pick;
               if (pick == SEL_IDLE)
                  state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = SEL_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign Grant     = grant_q;
   assign Selector  = sel_q;
   assign Out_Valid = valid_q;

   Multiplexer3to1 #(
      .NBits(NBits)
   ) u_mux (
      .sel(sel_q),
      .d0 (Data0),
      .d1 (Data1),
      .d2 (Data2),
      .y  (Out_Data)
   );

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed and randomized bench for mux3_rr_arbiter.
// Outputs are compared to a cycle-level ownership model of the arbiter rules.
module tb_mux3_rr_arbiter;

   localparam int NB = 32;
   localparam int MH = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [2:0]    Request = 3'b000;
   logic [NB-1:0] Data0 = '0;
   logic [NB-1:0] Data1 = '0;
   logic [NB-1:0] Data2 = '0;
   logic [2:0]    Grant;
   logic [1:0]    Selector;
   logic [NB-1:0] Out_Data;
   logic          Out_Valid;

   int checks = 0;
   int errors = 0;

   // Model: owner index (-1 idle), cycles held so far, priority pointer.
   int m_owner = -1;
   int m_held  = 0;
   int m_next  = 0;

   mux3_rr_arbiter #(.NBits(NB), .MaxHold(MH)) dut (
      .clk      (clk),
      .reset    (reset),
      .Request  (Request),
      .Data0    (Data0),
      .Data1    (Data1),
      .Data2    (Data2),
      .Grant    (Grant),
      .Selector (Selector),
      .Out_Data (Out_Data),
      .Out_Valid(Out_Valid)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_owner = -1;
      m_held  = 0;
      m_next  = 0;
   endfunction

   function automatic int first_req(input logic [2:0] r, input int p);
      for (int k = 0; k < 3; k++) begin
         if (r[(p + k) % 3]) return (p + k) % 3;
      end
      return -1;
   endfunction

   function automatic void model_edge(input logic [2:0] r);
      logic [2:0] own;
      logic       others;
      if (!reset) begin
         model_reset();
         return;
      end
      if (m_owner < 0) begin
         m_owner = first_req(r, m_next);
         m_held  = 1;
      end else begin
         own    = 3'b001 << m_owner;
         others = (r & ~own) != 3'b000;
         if (r[m_owner] && (m_held < MH || !others)) begin
            m_held++;
         end else begin
            m_next  = (m_owner + 1) % 3;
            m_owner = first_req(r, m_next);
            m_held  = 1;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [NB-1:0] obs,
                      input logic [NB-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [2:0]    eg;
      logic [1:0]    es;
      logic [NB-1:0] ed;
      eg = 3'b000;
      es = 2'b11;
      ed = '0;
      if (m_owner >= 0) begin
         eg = 3'b001 << m_owner;
         es = 2'(m_owner);
         ed = (m_owner == 0) ? Data0 : (m_owner == 1) ? Data1 : Data2;
      end
      chk({tag, ".grant"}, NB'(Grant), NB'(eg));
      chk({tag, ".sel"}, NB'(Selector), NB'(es));
      chk({tag, ".valid"}, NB'(Out_Valid), NB'(m_owner >= 0));
      chk({tag, ".data"}, Out_Data, ed);
   endtask

   task automatic step(input logic [2:0] r, input string tag);
      Request = r;
      model_edge(r);
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   initial begin
      Data0 = 32'hA5A5_0000;
      Data1 = 32'h1111_2222;
      Data2 = 32'h3333_4444;
      model_reset();
      Request = 3'b111;
      step(3'b111, "rst_hold");
      step(3'b111, "rst_hold");
      chk("rst.grant", NB'(Grant), NB'(3'b000));
      chk("rst.sel", NB'(Selector), NB'(2'b11));
      chk("rst.data", Out_Data, '0);

      reset = 1'b1;
      step(3'b111, "first");
      chk("first.grant", NB'(Grant), NB'(3'b001));
      chk("first.valid", NB'(Out_Valid), NB'(1'b1));
      for (int i = 0; i < 13; i++) step(3'b111, "rotate");
      chk("rotate.grant", NB'(Grant), NB'(3'b001));

      step(3'b000, "drain");
      step(3'b000, "drain");
      for (int i = 0; i < 20; i++) step(3'b010, "solo1");
      chk("solo1.grant", NB'(Grant), NB'(3'b010));
      step(3'b000, "solo1_rel");
      step(3'b000, "idle");

      step(3'b100, "own2");
      step(3'b101, "own2_hold");
      step(3'b001, "own2_drop");
      chk("wrap.grant", NB'(Grant), NB'(3'b001));
      chk("wrap.data", Out_Data, 32'hA5A5_0000);
      step(3'b001, "own0_hold");

      #2;
      reset = 1'b0;
      #1;
      chk("async.grant", NB'(Grant), NB'(3'b000));
      chk("async.sel", NB'(Selector), NB'(2'b11));
      chk("async.valid", NB'(Out_Valid), NB'(1'b0));
      model_reset();
      step(3'b001, "in_rst");
      reset = 1'b1;
      step(3'b000, "post_rst");

      step(3'b010, "pulse");
      chk("pulse.grant", NB'(Grant), NB'(3'b010));
      step(3'b000, "pulse_rel");
      chk("pulse_rel.grant", NB'(Grant), NB'(3'b000));
      step(3'b000, "pulse_idle");
      step(3'b111, "next2");
      chk("next2.grant", NB'(Grant), NB'(3'b100));

      for (int i = 0; i < 400; i++) begin
         Data0 = $urandom;
         Data1 = $urandom;
         Data2 = $urandom;
         if ($urandom_range(0, 3) == 0)
            step(3'($urandom_range(0, 7)), "rand");
         else
            step(Request, "rand_hold");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
